// File: rtl/alarm_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_trigger_ctrl
// Purpose  : Rings the buzzer on a new time/alarm digit match; handles stop,
//            snooze (limited count) and ring timeout in tick units.
//            Optional macro ALARM_TRIGGER_BUZZER_PULSE_EN: beep at tick rate.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_trigger_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SNOOZE_TICKS = 300,
    parameter int RING_TIMEOUT = 120,
    parameter int MAX_SNOOZES  = 3
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [4*NUM_DIGITS-1:0]          time_digits,
    input  logic [4*NUM_DIGITS-1:0]          alarm_digits,
    input  logic                             alarm_en,
    input  logic                             tick,
    input  logic                             snooze_btn,
    input  logic                             stop_btn,
    output logic                             buzzer,
    output logic                             ringing,
    output logic                             snoozing,
    output logic [$clog2(MAX_SNOOZES+1)-1:0] snooze_count
);

    localparam int RW = $clog2(RING_TIMEOUT + 1);
    localparam int SW = $clog2(SNOOZE_TICKS + 1);
    localparam int CW = $clog2(MAX_SNOOZES + 1);

    localparam logic [RW-1:0] c_ring_last  = RW'(RING_TIMEOUT - 1);
    localparam logic [SW-1:0] c_snz_load   = SW'(SNOOZE_TICKS);
    localparam logic [SW-1:0] c_snz_last   = SW'(1);
    localparam logic [CW-1:0] c_max_snooze = CW'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_ring_cnt;
    logic [RW-1:0]   w_ring_cnt_nxt;
    logic [SW-1:0]   r_snz_cnt;
    logic [SW-1:0]   w_snz_cnt_nxt;
    logic [CW-1:0]   r_snooze_count;
    logic [CW-1:0]   w_snooze_count_nxt;
    logic            r_match_d;
    logic            r_buzzer;
    logic            r_ringing;
    logic            r_snoozing;
    logic            w_match_now;
    logic            w_match_rise;
    logic            w_buzzer_nxt;

    // Edge-detect on the match so an already-matching minute never (re)rings.
    assign w_match_now  = (time_digits == alarm_digits);
    assign w_match_rise = w_match_now & ~r_match_d;

    always_comb begin
        w_state_nxt        = r_state;
        w_ring_cnt_nxt     = r_ring_cnt;
        w_snz_cnt_nxt      = r_snz_cnt;
        w_snooze_count_nxt = r_snooze_count;

        if (!alarm_en) begin
            w_state_nxt        = ST_IDLE;
            w_ring_cnt_nxt     = '0;
            w_snz_cnt_nxt      = '0;
            w_snooze_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_match_rise) begin
                        w_state_nxt        = ST_RINGING;
                        w_ring_cnt_nxt     = '0;
                        w_snooze_count_nxt = '0;
                    end
                end
                ST_RINGING: begin
                    if (stop_btn) begin
                        w_state_nxt        = ST_IDLE;
                        w_ring_cnt_nxt     = '0;
                        w_snooze_count_nxt = '0;
                    end else if (snooze_btn && (r_snooze_count < c_max_snooze)) begin
                        w_state_nxt        = ST_SNOOZE;
                        w_snz_cnt_nxt      = c_snz_load;
                        w_snooze_count_nxt = r_snooze_count + CW'(1);
                    end else if (tick) begin
                        if (r_ring_cnt == c_ring_last) begin
                            w_state_nxt        = ST_IDLE;
                            w_ring_cnt_nxt     = '0;
                            w_snooze_count_nxt = '0;
                        end else begin
                            w_ring_cnt_nxt = r_ring_cnt + RW'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_btn) begin
                        w_state_nxt        = ST_IDLE;
                        w_snz_cnt_nxt      = '0;
                        w_snooze_count_nxt = '0;
                    end else if (tick) begin
                        if (r_snz_cnt == c_snz_last) begin
                            w_state_nxt    = ST_RINGING;
                            w_ring_cnt_nxt = '0;
                            w_snz_cnt_nxt  = '0;
                        end else begin
                            w_snz_cnt_nxt = r_snz_cnt - SW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt        = ST_IDLE;
                    w_ring_cnt_nxt     = '0;
                    w_snz_cnt_nxt      = '0;
                    w_snooze_count_nxt = '0;
                end
            endcase
        end
    end

`ifdef ALARM_TRIGGER_BUZZER_PULSE_EN
    // Start high on entry, flip on each tick that keeps us ringing.
    always_comb begin
        w_buzzer_nxt = 1'b0;
        if (w_state_nxt == ST_RINGING) begin
            if (r_state != ST_RINGING) begin
                w_buzzer_nxt = 1'b1;
            end else if (tick) begin
                w_buzzer_nxt = ~r_buzzer;
            end else begin
                w_buzzer_nxt = r_buzzer;
            end
        end
    end
`else
    always_comb begin
        w_buzzer_nxt = (w_state_nxt == ST_RINGING);
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_ring_cnt     <= '0;
            r_snz_cnt      <= '0;
            r_snooze_count <= '0;
            r_match_d      <= 1'b0;
            r_buzzer       <= 1'b0;
            r_ringing      <= 1'b0;
            r_snoozing     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ring_cnt     <= w_ring_cnt_nxt;
            r_snz_cnt      <= w_snz_cnt_nxt;
            r_snooze_count <= w_snooze_count_nxt;
            r_match_d      <= w_match_now;
            r_buzzer       <= w_buzzer_nxt;
            r_ringing      <= (w_state_nxt == ST_RINGING);
            r_snoozing     <= (w_state_nxt == ST_SNOOZE);
        end
    end

    assign buzzer       = r_buzzer;
    assign ringing      = r_ringing;
    assign snoozing     = r_snoozing;
    assign snooze_count = r_snooze_count;

endmodule
`default_nettype wire

// File: tb/tb_alarm_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_trigger_ctrl
// Purpose  : Directed plus randomized check of alarm_trigger_ctrl against a
//            behavioural model (honours ALARM_TRIGGER_BUZZER_PULSE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_trigger_ctrl;

    localparam int NUM_DIGITS   = 4;
    localparam int SNOOZE_TICKS = 3;
    localparam int RING_TIMEOUT = 4;
    localparam int MAX_SNOOZES  = 2;
    localparam int CW           = $clog2(MAX_SNOOZES + 1);

    logic                    clk = 1'b0;
    logic                    resetn;
    logic [4*NUM_DIGITS-1:0] time_digits;
    logic [4*NUM_DIGITS-1:0] alarm_digits;
    logic                    alarm_en;
    logic                    tick;
    logic                    snooze_btn;
    logic                    stop_btn;
    logic                    buzzer;
    logic                    ringing;
    logic                    snoozing;
    logic [CW-1:0]           snooze_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = quiet, 1 = ringing, 2 = snoozing.
    int m_mode       = 0;
    int m_rung       = 0;
    int m_snz_left   = 0;
    int m_used       = 0;
    bit m_prev_match = 1'b0;
    bit m_buz        = 1'b0;

    always #5 clk = ~clk;

    alarm_trigger_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SNOOZE_TICKS (SNOOZE_TICKS),
        .RING_TIMEOUT (RING_TIMEOUT),
        .MAX_SNOOZES  (MAX_SNOOZES)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .time_digits  (time_digits),
        .alarm_digits (alarm_digits),
        .alarm_en     (alarm_en),
        .tick         (tick),
        .snooze_btn   (snooze_btn),
        .stop_btn     (stop_btn),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_count (snooze_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit rst_n, input bit t, input bit snz, input bit stp);
        int  old_mode;
        bit  match;
        bit  rise;
        old_mode = m_mode;
        match    = (time_digits == alarm_digits);
        rise     = match && !m_prev_match;
        if (!rst_n) begin
            m_mode = 0; m_rung = 0; m_snz_left = 0; m_used = 0;
            m_prev_match = 1'b0; m_buz = 1'b0;
            return;
        end
        m_prev_match = match;
        if (!alarm_en) begin
            m_mode = 0; m_rung = 0; m_snz_left = 0; m_used = 0;
        end else if (m_mode == 0) begin
            if (rise) begin m_mode = 1; m_rung = 0; m_used = 0; end
        end else if (m_mode == 1) begin
            if (stp) begin
                m_mode = 0; m_used = 0;
            end else if (snz && m_used < MAX_SNOOZES) begin
                m_mode = 2; m_snz_left = SNOOZE_TICKS; m_used++;
            end else if (t) begin
                m_rung++;
                if (m_rung >= RING_TIMEOUT) begin m_mode = 0; m_used = 0; end
            end
        end else begin
            if (stp) begin
                m_mode = 0; m_used = 0;
            end else if (t) begin
                m_snz_left--;
                if (m_snz_left == 0) begin m_mode = 1; m_rung = 0; end
            end
        end
`ifdef ALARM_TRIGGER_BUZZER_PULSE_EN
        if (m_mode != 1)        m_buz = 1'b0;
        else if (old_mode != 1) m_buz = 1'b1;
        else if (t)             m_buz = ~m_buz;
`else
        m_buz = (m_mode == 1);
`endif
    endtask

    // One clock: drive on negedge, advance model, sample 1 time unit after posedge.
    task automatic cyc(input logic [15:0] td, input bit en, input bit t,
                       input bit snz, input bit stp, input bit rst_n = 1'b1);
        @(negedge clk);
        time_digits = td;
        alarm_en    = en;
        tick        = t;
        snooze_btn  = snz;
        stop_btn    = stp;
        resetn      = rst_n;
        model_update(rst_n, t, snz, stp);
        @(posedge clk);
        #1;
        chk("m_ringing",  {31'd0, ringing},  {31'd0, m_mode == 1});
        chk("m_snoozing", {31'd0, snoozing}, {31'd0, m_mode == 2});
        chk("m_count",    32'(snooze_count), 32'(m_used));
        chk("m_buzzer",   {31'd0, buzzer},   {31'd0, m_buz});
    endtask

    task automatic trigger();
        cyc(16'h0731, 1, 0, 0, 0);
        cyc(16'h0730, 1, 0, 0, 0);
    endtask

    initial begin
        resetn = 1'b0; time_digits = 16'h0000; alarm_digits = 16'h0730;
        alarm_en = 1'b0; tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;

        // Reset state
        cyc(16'h0000, 0, 0, 0, 0, 0);
        cyc(16'h0000, 0, 0, 0, 0, 0);
        chk("rst_ringing", {31'd0, ringing}, 32'd0);
        chk("rst_buzzer",  {31'd0, buzzer},  32'd0);
        chk("rst_count",   32'(snooze_count), 32'd0);

        // 1: trigger, stop, no re-ring in same minute
        cyc(16'h0729, 1, 0, 0, 0);
        chk("t1_pre", {31'd0, ringing}, 32'd0);
        cyc(16'h0730, 1, 0, 0, 0);
        chk("t1_ring",   {31'd0, ringing}, 32'd1);
        chk("t1_buzzer", {31'd0, buzzer},  32'd1);
        cyc(16'h0730, 1, 0, 0, 1);
        chk("t1_stop", {31'd0, ringing}, 32'd0);
        repeat (3) cyc(16'h0730, 1, 1, 0, 0);
        chk("t1_hold", {31'd0, ringing}, 32'd0);

        // 2: snooze cycle and snooze limit
        trigger();
        cyc(16'h0730, 1, 0, 1, 0);
        chk("t2_snz1",  {31'd0, snoozing}, 32'd1);
        chk("t2_cnt1",  32'(snooze_count), 32'd1);
        repeat (2) cyc(16'h0730, 1, 1, 0, 0);
        chk("t2_still", {31'd0, snoozing}, 32'd1);
        cyc(16'h0730, 1, 1, 0, 0);
        chk("t2_rering", {31'd0, ringing}, 32'd1);
        cyc(16'h0730, 1, 0, 1, 0);
        chk("t2_cnt2", 32'(snooze_count), 32'd2);
        repeat (3) cyc(16'h0730, 1, 1, 0, 0);
        cyc(16'h0730, 1, 0, 1, 0);
        chk("t2_limit", {31'd0, ringing}, 32'd1);
        chk("t2_cnt_l", 32'(snooze_count), 32'd2);
        cyc(16'h0730, 1, 0, 0, 1);

        // 3: timeout after RING_TIMEOUT ticks
        trigger();
        repeat (3) cyc(16'h0730, 1, 1, 0, 0);
        chk("t3_before", {31'd0, ringing}, 32'd1);
        cyc(16'h0730, 1, 1, 0, 0);
        chk("t3_timeout", {31'd0, ringing}, 32'd0);
        chk("t3_cnt",     32'(snooze_count), 32'd0);

        // 4: arming while already matching does not ring
        cyc(16'h0730, 0, 0, 0, 0);
        repeat (2) cyc(16'h0730, 1, 0, 0, 0);
        chk("t4_noring", {31'd0, ringing}, 32'd0);
        trigger();
        chk("t4_ring", {31'd0, ringing}, 32'd1);

        // 5: priorities
        cyc(16'h0730, 1, 0, 1, 1);
        chk("t5_stopwins", {31'd0, ringing | snoozing}, 32'd0);
        trigger();
        cyc(16'h0730, 1, 1, 1, 0);
        chk("t5_snzwins", {31'd0, snoozing}, 32'd1);
        repeat (2) cyc(16'h0730, 1, 1, 0, 0);
        chk("t5_snz3a", {31'd0, snoozing}, 32'd1);
        cyc(16'h0730, 1, 1, 0, 0);
        chk("t5_snz3b", {31'd0, ringing}, 32'd1);
        cyc(16'h0730, 1, 0, 1, 0);
        cyc(16'h0730, 0, 0, 0, 0);
        chk("t5_en_off", {31'd0, snoozing | ringing}, 32'd0);
        chk("t5_en_cnt", 32'(snooze_count), 32'd0);

        // 6: reset mid-snooze, then still-matching time re-triggers
        trigger();
        cyc(16'h0730, 1, 0, 1, 0);
        cyc(16'h0730, 1, 0, 0, 0, 0);
        chk("t6_rst", {28'd0, buzzer, ringing, snoozing, |snooze_count}, 32'd0);
        cyc(16'h0730, 1, 0, 0, 0);
        chk("t6_retrig", {31'd0, ringing}, 32'd1);
        chk("t6_buz0",   {31'd0, buzzer},  32'd1);
`ifdef ALARM_TRIGGER_BUZZER_PULSE_EN
        cyc(16'h0730, 1, 1, 0, 0);
        chk("t6_buz1", {31'd0, buzzer}, 32'd0);
        cyc(16'h0730, 1, 1, 0, 0);
        chk("t6_buz2", {31'd0, buzzer}, 32'd1);
`else
        cyc(16'h0730, 1, 1, 0, 0);
        chk("t6_steady", {31'd0, buzzer}, 32'd1);
`endif
        cyc(16'h0730, 1, 0, 0, 1);

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] td;
            int          sel;
            sel = int'($urandom_range(0, 9));
            td  = (sel < 5) ? 16'h0730 : (sel < 9) ? 16'h0731 : 16'($urandom);
            cyc(td,
                $urandom_range(0, 29) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 199) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
